// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and divider state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_LESS = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_seq_if.sv
// ALU operand/result bus; the divider drives it as master, the ALU answers as slave.
interface alu_div_seq_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ch;
  logic [3:0] alu_f;
  logic       cout_f;
  logic       zero_f;

  modport master (output alu_a, alu_b, alu_ch, input alu_f, cout_f, zero_f);
  modport slave  (input alu_a, alu_b, alu_ch, output alu_f, cout_f, zero_f);
endinterface

// File: rtl/alu4.sv
// Combinational 4-bit ALU shared by the lab datapath.
module alu4
  import alu_pkg::*;
(
  alu_div_seq_if.slave alu
);
  logic [4:0] sum;

  always_comb begin
    sum        = 5'd0;
    alu.alu_f  = 4'd0;
    alu.cout_f = 1'b0;
    case (alu.alu_ch)
      ALU_ADD: begin
        sum        = {1'b0, alu.alu_a} + {1'b0, alu.alu_b};
        alu.alu_f  = sum[3:0];
        alu.cout_f = sum[4];
      end
      ALU_SUB: begin
        sum        = {1'b0, alu.alu_a} + {1'b0, ~alu.alu_b} + 5'd1;
        alu.alu_f  = sum[3:0];
        alu.cout_f = sum[4];
      end
      ALU_AND:  alu.alu_f = alu.alu_a & alu.alu_b;
      ALU_OR:   alu.alu_f = alu.alu_a | alu.alu_b;
      ALU_XOR:  alu.alu_f = alu.alu_a ^ alu.alu_b;
      ALU_LESS: alu.alu_f = {3'b000, alu.alu_a < alu.alu_b};
      default:  alu.alu_f = 4'd0;
    endcase
    alu.zero_f = (alu.alu_f == 4'd0);
  end
endmodule

// File: rtl/alu_div_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, keep the ALU
// difference when it did not borrow.
module div_step (
  input  logic [2:0] r,       // remainder bit 3 is always zero before a shift
  input  logic [3:0] q,
  input  logic [3:0] alu_f,
  input  logic       cout_f,
  output logic [3:0] rs,
  output logic [3:0] r_nxt,
  output logic [3:0] q_nxt
);
  assign rs    = {r, q[3]};
  assign r_nxt = cout_f ? alu_f : rs;
  assign q_nxt = {q[2:0], cout_f};
endmodule

// File: rtl/alu_div_seq.sv
// Sequential 4-bit unsigned restoring divider; one quotient bit per cycle
// using subtracts issued on an external ALU.
module alu_div_seq
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          dividend,
  input  logic [3:0]          divisor,
  output logic                busy,
  output logic                done,
  output logic [3:0]          quotient,
  output logic [3:0]          remainder,
  output logic                div0,
  alu_div_seq_if.master       alu
);
  div_state_e state;
  logic [3:0] r_q, q_q, d_q;
  logic [1:0] cnt;
  logic [3:0] rs, r_nxt, q_nxt;

  div_step u_step (
    .r      (r_q[2:0]),
    .q      (q_q),
    .alu_f  (alu.alu_f),
    .cout_f (alu.cout_f),
    .rs     (rs),
    .r_nxt  (r_nxt),
    .q_nxt  (q_nxt)
  );

  // ALU drive depends only on registered state, so no loop through the ALU.
  always_comb begin
    alu.alu_a  = 4'd0;
    alu.alu_b  = 4'd0;
    alu.alu_ch = ALU_ADD;
    if (state == S_ITER) begin
      alu.alu_a  = rs;
      alu.alu_b  = d_q;
      alu.alu_ch = ALU_SUB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      div0      <= 1'b0;
      r_q       <= 4'd0;
      q_q       <= 4'd0;
      d_q       <= 4'd0;
      cnt       <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == 4'd0) begin
              quotient  <= 4'hF;
              remainder <= dividend;
              div0      <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              q_q   <= dividend;
              d_q   <= divisor;
              r_q   <= 4'd0;
              cnt   <= 2'd3;
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt - 2'd1;
          if (cnt == 2'd0) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
            div0      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq driving the real ALU on its bus.
module tb_alu_div_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy, done, div0;
  logic [3:0] quotient, remainder;
  int         n_tests = 0;
  int         n_fail = 0;

  alu_div_seq_if bus ();

  alu_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .alu       (bus)
  );

  alu4 u_alu (.alu(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start in cycle 0, follow to done, check latency/results, then IDLE next cycle.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic ed0, input int lat);
    int cyc;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 10) begin
      chk("iter_busy", {31'd0, busy}, 32'd1);
      chk("iter_alu_ch", {29'd0, bus.alu_ch}, 32'd1);
      tick();
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("quotient", {28'd0, quotient}, {28'd0, eq});
    chk("remainder", {28'd0, remainder}, {28'd0, er});
    chk("div0", {31'd0, div0}, {31'd0, ed0});
    chk("done_busy", {31'd0, busy}, 32'd1);
    chk("done_alu_ch", {29'd0, bus.alu_ch}, 32'd0);
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", {28'd0, quotient}, 32'd0);
    chk("rst_r", {28'd0, remainder}, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    chk("rst_alu_ch", {29'd0, bus.alu_ch}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    do_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5);
    do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
    do_div(4'd14, 4'd15, 4'd0, 4'd14, 1'b0, 5);
    do_div(4'd9, 4'd9, 4'd1, 4'd0, 1'b0, 5);
    do_div(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1);

    // 12/5 with ignored starts in cycles 2 and 5, then accepted start in cycle 6.
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    ndone = 0;
    tick();                                   // cycle 2
    dividend = 4'd3; divisor = 4'd1; start = 1'b1;
    tick();                                   // cycle 3
    start = 1'b0;
    if (done) ndone++;
    tick();                                   // cycle 4
    if (done) ndone++;
    tick();                                   // cycle 5
    chk("b2b_done5", {31'd0, done}, 32'd1);
    chk("b2b_q", {28'd0, quotient}, 32'd2);
    chk("b2b_r", {28'd0, remainder}, 32'd2);
    start = 1'b1;
    tick();                                   // cycle 6
    chk("b2b_idle6", {31'd0, busy}, 32'd0);
    chk("b2b_single_done", ndone, 0);
    // start held high into cycle 6 is the accepted one
    tick();                                   // cycle 7
    start = 1'b0;
    chk("b2b_busy7", {31'd0, busy}, 32'd1);
    for (int c = 7; c < 11; c++) begin
      chk("b2b_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    chk("b2b_done11", {31'd0, done}, 32'd1);
    chk("b2b_q2", {28'd0, quotient}, 32'd3);
    chk("b2b_r2", {28'd0, remainder}, 32'd0);
    tick();

    // Abort 11/2 with reset in cycle 3.
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();                                   // cycle 3
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", {28'd0, quotient}, 32'd0);
    chk("abort_r", {28'd0, remainder}, 32'd0);
    chk("abort_alu_a", {28'd0, bus.alu_a}, 32'd0);
    chk("abort_alu_b", {28'd0, bus.alu_b}, 32'd0);
    chk("abort_alu_ch", {29'd0, bus.alu_ch}, 32'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    do_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5);

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        do_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
